max_pool_2x2: RTL and testbench

- Streaming 2x2, stride-2 signed max-pooling stage directly upstream of the activation stage.
- Consumes full-precision 2*DW accumulator results from the systolic array in raster order (row-major, one pixel per in_valid).
- Emits pooled values with a one-cycle out_flag_pooling strobe; that strobe and data_out feed the activation stage's out_flag_pooling and data_in ports unchanged.
- Bypass mode (pool_en=0) forwards every input with the same one-cycle timing, for layers without pooling.

---
 rtl/max_pool_2x2_if.sv | 24 ++
 rtl/max_pool_2x2.sv | 69 ++++++
 tb/tb_max_pool_2x2.sv | 125 ++++++++++++
 3 files changed

// File: rtl/max_pool_2x2_if.sv
// max_pool_2x2_if: control, pixel stream and result stream between a producer and the pooling stage
interface max_pool_2x2_if #(
  parameter int DW = 32,
  parameter int CW = 8
);
  logic                   start;
  logic                   pool_en;
  logic [CW-1:0]          fmap_w;
  logic [CW-1:0]          fmap_h;
  logic                   in_valid;
  logic signed [2*DW-1:0] data_in;
  logic signed [2*DW-1:0] data_out;
  logic                   out_flag_pooling;
  logic                   busy;
  logic                   pool_done;
  modport master (
    output start, pool_en, fmap_w, fmap_h, in_valid, data_in,
    input  data_out, out_flag_pooling, busy, pool_done
  );
  modport slave (
    input  start, pool_en, fmap_w, fmap_h, in_valid, data_in,
    output data_out, out_flag_pooling, busy, pool_done
  );
endinterface

// File: rtl/max_pool_2x2.sv
// max_pool_2x2: streaming 2x2 stride-2 signed max-pool over a raster feature map, with bypass
module max_pool_2x2 #(
  parameter int DW    = 32,
  parameter int MAX_W = 32,
  parameter int CW    = 8
) (
  input logic           clk,
  input logic           rst,
  max_pool_2x2_if.slave bus
);
  localparam int LD = MAX_W / 2;
  localparam int AW = LD > 1 ? $clog2(LD) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t                 state, state_nx;
  logic                   pool_q;
  logic [CW-1:0]          w_q, h_q, col, row;
  logic signed [2*DW-1:0] h, pair, lb_q, res;
  logic signed [2*DW-1:0] lb [LD];
  logic [AW-1:0]          idx;
  logic                   acc, col_end, last, emit;
  assign idx     = AW'(col >> 1);
  assign acc     = state == RUN && bus.in_valid;
  assign col_end = col == w_q - CW'(1);
  assign last    = acc && col_end && row == h_q - CW'(1);
  // a window completes on the odd column of an odd row
  assign emit    = acc && (!pool_q || (col[0] && row[0]));
  assign lb_q    = lb[idx];
  assign bus.busy      = state == RUN;
  assign bus.pool_done = state == DONE;
  always_comb begin
    pair     = h > bus.data_in ? h : bus.data_in;
    res      = lb_q > pair ? lb_q : pair;
    state_nx = state == IDLE ? (bus.start ? RUN : IDLE) :
               state == RUN  ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pool_q               <= 1'b0;
      w_q                  <= '0;
      h_q                  <= '0;
      col                  <= '0;
      row                  <= '0;
      h                    <= '0;
      bus.data_out         <= '0;
      bus.out_flag_pooling <= 1'b0;
      for (int i = 0; i < LD; i++) lb[i] <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        pool_q <= bus.pool_en;
        w_q    <= bus.fmap_w;
        h_q    <= bus.fmap_h;
        col    <= '0;
        row    <= '0;
      end
      if (acc) begin
        col <= col_end ? '0 : col + CW'(1);
        row <= col_end ? row + CW'(1) : row;
        if (!col[0]) h <= bus.data_in;
        // even rows fully rewrite their entries, so stale maps never leak
        if (pool_q && col[0] && !row[0]) lb[idx] <= pair;
      end
      bus.out_flag_pooling <= emit;
      bus.data_out         <= emit ? (pool_q ? res : bus.data_in) : '0;
    end
  end
endmodule

// File: tb/tb_max_pool_2x2.sv
// tb_max_pool_2x2: directed self-checking bench for max_pool_2x2
module tb_max_pool_2x2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic s;
  logic [63:0] v [8];
  max_pool_2x2_if #(.DW(32), .CW(8)) bus ();
  max_pool_2x2 #(.DW(32), .MAX_W(32), .CW(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic pe, input logic [7:0] w, input logic [7:0] hh);
    bus.start = 1'b1; bus.pool_en = pe; bus.fmap_w = w; bus.fmap_h = hh;
    @(negedge clk);
    bus.start = 1'b0;
    chk("busy after start", 64'(bus.busy), 64'd1);
  endtask
  task automatic pix(input logic [63:0] d, input logic ef, input logic [63:0] ed, input string tag);
    bus.in_valid = 1'b1; bus.data_in = d;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, " flag"}, 64'(bus.out_flag_pooling), 64'(ef));
    chk({tag, " data"}, bus.data_out, ed);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      bus.in_valid = 1'b0; bus.data_in = {$urandom, $urandom};
      @(negedge clk);
      chk("idle flag", 64'(bus.out_flag_pooling), 64'd0);
      chk("idle data", bus.data_out, 64'd0);
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.pool_en = 1'b0; bus.fmap_w = '0; bus.fmap_h = '0;
    bus.in_valid = 1'b0; bus.data_in = '0;
    #3;
    chk("reset flag", 64'(bus.out_flag_pooling), 64'd0);
    chk("reset data", bus.data_out, 64'd0);
    chk("reset busy", 64'(bus.busy), 64'd0);
    chk("reset done", 64'(bus.pool_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    go(1'b1, 8'd4, 8'd4);
    for (int i = 1; i <= 16; i++) begin
      s = (i == 6 || i == 8 || i == 14 || i == 16);
      pix(64'(i), s, s ? 64'(i) : 64'd0, "basic");
      chk("basic done", 64'(bus.pool_done), 64'(i == 16));
    end
    bus.in_valid = 1'b1; bus.data_in = 64'd99;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("idle in_valid flag", 64'(bus.out_flag_pooling), 64'd0);
    chk("idle busy", 64'(bus.busy), 64'd0);
    chk("idle done", 64'(bus.pool_done), 64'd0);
    go(1'b1, 8'd2, 8'd2);
    pix(-64'sd5, 1'b0, 64'd0, "neg");
    pix(-64'sd3, 1'b0, 64'd0, "neg");
    pix(-64'sd9, 1'b0, 64'd0, "neg");
    pix(-64'sd4, 1'b1, -64'sd3, "neg");
    chk("neg done", 64'(bus.pool_done), 64'd1);
    @(negedge clk);
    go(1'b1, 8'd2, 8'd2);
    pix(64'h8000_0000_0000_0000, 1'b0, 64'd0, "minint");
    pix(-64'sd1, 1'b0, 64'd0, "minint");
    pix(-64'sd2, 1'b0, 64'd0, "minint");
    pix(-64'sd3, 1'b1, -64'sd1, "minint");
    idle(1);
    go(1'b0, 8'd2, 8'd4);
    for (int i = 0; i < 8; i++) begin
      pix(64'(10 + i), 1'b1, 64'(10 + i), "bypass");
      chk("bypass done", 64'(bus.pool_done), 64'(i == 7));
      if (i < 7) idle($urandom_range(0, 2));
    end
    idle(1);
    v = '{64'd1000, 64'd2, 64'd3, 64'd4, 64'd5, 64'd6, 64'd7, 64'd8};
    go(1'b1, 8'd4, 8'd2);
    for (int i = 0; i < 8; i++)
      pix(v[i], i == 5 || i == 7, i == 5 ? 64'd1000 : i == 7 ? 64'd8 : 64'd0, "b2b first");
    chk("b2b first done", 64'(bus.pool_done), 64'd1);
    bus.start = 1'b1; bus.fmap_w = 8'd2; bus.fmap_h = 8'd2;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start in done ignored", 64'(bus.busy), 64'd0);
    go(1'b1, 8'd2, 8'd2);
    for (int i = 0; i < 4; i++) pix(-64'sd7, i == 3, i == 3 ? -64'sd7 : 64'd0, "b2b second");
    idle(1);
    go(1'b1, 8'd4, 8'd4);
    for (int i = 1; i <= 5; i++) pix(64'(i), 1'b0, 64'd0, "pre reset");
    #2 rst = 1'b1;
    #1;
    chk("midrst flag", 64'(bus.out_flag_pooling), 64'd0);
    chk("midrst data", bus.data_out, 64'd0);
    chk("midrst busy", 64'(bus.busy), 64'd0);
    chk("midrst done", 64'(bus.pool_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.data_in = 64'd55;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("post reset no strobe", 64'(bus.out_flag_pooling), 64'd0);
    go(1'b1, 8'd2, 8'd2);
    for (int i = 1; i <= 4; i++) pix(64'(i), i == 4, i == 4 ? 64'd4 : 64'd0, "post reset map");
    idle(1);
    go(1'b1, 8'd4, 8'd2);
    pix(64'd1, 1'b0, 64'd0, "ign start");
    pix(64'd2, 1'b0, 64'd0, "ign start");
    bus.start = 1'b1; bus.fmap_w = 8'd2;
    pix(64'd3, 1'b0, 64'd0, "ign start");
    bus.start = 1'b0; bus.fmap_w = 8'd4;
    for (int i = 4; i <= 8; i++) begin
      pix(64'(i), i == 6 || i == 8, (i == 6 || i == 8) ? 64'(i) : 64'd0, "ign start");
      chk("ign start done", 64'(bus.pool_done), 64'(i == 8));
    end
    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
